// File: rtl/q_quantizer.sv
// ---------------------------------------------------------------------------
// q_quantizer
//   Registered 4-bit -> 2-bit quadratic-form evaluator over Z4:
//     Qx = (x0 + x1 + x2 + x3 + 2*x0*x1 + 2*x2*x3) mod 4
//   One cycle of latency, one result per cycle, with a valid flag.
//
//   Optional build macro: Q_LUT_EN
//     When defined, Qx is looked up in a 16 x 2-bit register table that
//     software may rewrite through wr_en/wr_addr/wr_data. Reset reloads
//     the table with the fixed formula. When undefined, the write port is
//     ignored and no table storage exists.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   x is valid this cycle
//   x[3:0]     in   operand
//   wr_en      in   table write strobe (Q_LUT_EN only)
//   wr_addr    in   table entry index
//   wr_data    in   table entry value
//   out_valid  out  Qx is valid
//   Qx[1:0]    out  Q(x) mod 4
// ---------------------------------------------------------------------------
module q_quantizer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] x,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [1:0] wr_data,
  output logic       out_valid,
  output logic [1:0] Qx
);

  // Fixed quadratic form. The cross terms are doubled, so only their
  // parity matters for bit 1 of the mod-4 result.
  function automatic logic [1:0] f_quad(input logic [3:0] v);
    logic [2:0] s;
    s = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    return s[1:0] + {(v[0] & v[1]) ^ (v[2] & v[3]), 1'b0};
  endfunction

  logic [1:0] w_q;

`ifdef Q_LUT_EN
  logic [1:0] r_lut [16];

  // Reset takes priority over a coincident write. A write and a lookup of
  // the same entry on the same edge see the old value because the read
  // below uses the pre-edge contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_lut[i] <= f_quad(4'(i));
      end
    end else if (wr_en) begin
      r_lut[wr_addr] <= wr_data;
    end
  end

  assign w_q = r_lut[x];
`else
  // Write port is present but has no function in this build.
  logic w_unused_wr;
  assign w_unused_wr = ^{wr_en, wr_addr, wr_data};

  assign w_q = f_quad(x);
`endif

  logic       r_out_valid;
  logic [1:0] r_qx;

  // Qx holds its last value while in_valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_qx        <= 2'b00;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_qx <= w_q;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign Qx        = r_qx;

endmodule

// File: tb/tb_q_quantizer.sv
// ---------------------------------------------------------------------------
// tb_q_quantizer
//   Directed plus random stimulus for q_quantizer, checked every cycle
//   against a behavioural model computed with plain integer arithmetic.
//   The same bench serves both builds; define Q_LUT_EN for the table build.
// ---------------------------------------------------------------------------
module tb_q_quantizer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] x;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [1:0] wr_data;
  logic       out_valid;
  logic [1:0] Qx;

  int errors = 0;
  int checks = 0;

  // Expected model state
  int exp_valid;
  int exp_q;
  int model_lut [16];

  q_quantizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_valid (out_valid),
    .Qx        (Qx)
  );

  always #5 clk = ~clk;

  // Quadratic form evaluated directly with integers.
  function automatic int ref_q(input int v);
    int b0, b1, b2, b3;
    b0 = v % 2;
    b1 = (v / 2) % 2;
    b2 = (v / 4) % 2;
    b3 = (v / 8) % 2;
    return (b0 + b1 + b2 + b3 + 2 * b0 * b1 + 2 * b2 * b3) % 4;
  endfunction

  function automatic void model_reset_lut();
    for (int i = 0; i < 16; i++) model_lut[i] = ref_q(i);
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: update the model from the current inputs, wait past the
  // edge, then compare both outputs.
  task automatic tick(input string tag);
    int lookup;
`ifdef Q_LUT_EN
    lookup = model_lut[int'(x)];
`else
    lookup = ref_q(int'(x));
`endif
    if (!rst_n) begin
      exp_valid = 0;
      exp_q     = 0;
`ifdef Q_LUT_EN
      model_reset_lut();
`endif
    end else begin
      exp_valid = in_valid ? 1 : 0;
      if (in_valid) exp_q = lookup;
`ifdef Q_LUT_EN
      if (wr_en) model_lut[int'(wr_addr)] = int'(wr_data);
`endif
    end
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, int'(out_valid), exp_valid);
    chk({tag, ".qx"}, int'(Qx), exp_q);
    $display("%t %-10s rst_n=%0b in_valid=%0b x=%0d wr_en=%0b -> out_valid=%0b Qx=%0d",
             $time, tag, rst_n, in_valid, x, wr_en, out_valid, Qx);
  endtask

  initial begin
    int table16 [16] = '{0, 1, 1, 0, 1, 2, 2, 1, 1, 2, 2, 1, 0, 1, 1, 0};

    model_reset_lut();
    exp_valid = 0;
    exp_q     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    x         = 4'b0101;
    wr_en     = 1'b0;
    wr_addr   = 4'd0;
    wr_data   = 2'd0;

    // Reset held two cycles with a valid input present
    tick("rst0");
    tick("rst1");
    chk("rst.qx_zero", int'(Qx), 0);
    rst_n = 1'b1;
    tick("post_rst");
    chk("post_rst.qx10", int'(Qx), 2);

    // Exhaustive sweep checked against the published table
    for (int i = 0; i < 16; i++) begin
      x        = 4'(i);
      in_valid = 1'b1;
      tick("sweep");
      chk("sweep.table", int'(Qx), table16[i]);
    end

    // Valid gating: Qx holds while out_valid drops
    x = 4'b0111; in_valid = 1'b1;
    tick("gate_on");
    for (int i = 0; i < 3; i++) begin
      x = 4'b0001; in_valid = 1'b0;
      tick("gate_off");
      chk("gate.hold", int'(Qx), 1);
    end

    // Back-to-back
    in_valid = 1'b1;
    x = 4'b1111; tick("b2b0");
    x = 4'b0001; tick("b2b1");
    x = 4'b1010; tick("b2b2");

    // Write port: write then look up entry 5 (ignored unless table build)
    in_valid = 1'b0; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 2'd0;
    tick("wr5");
    wr_en = 1'b0; in_valid = 1'b1; x = 4'b0101;
    tick("rd5");
`ifndef Q_LUT_EN
    chk("wr_ignored", int'(Qx), 2);
`endif

    // Same-address write and lookup, then reset restores the table
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 2'd3; x = 4'b0011; in_valid = 1'b1;
    tick("wr3_rd3");
    chk("wr3.old_entry", int'(Qx), 0);
    wr_en = 1'b0;
    tick("rd3_new");
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 2'd3;
    tick("rst_wr");
    rst_n = 1'b1; wr_en = 1'b0;
    tick("rd3_rst");
    chk("rst.restores", int'(Qx), 0);

    // Random traffic including occasional writes and resets
    for (int n = 0; n < 300; n++) begin
      rst_n    = ($urandom_range(0, 24) != 0);
      in_valid = $urandom_range(0, 3) != 0;
      x        = 4'($urandom_range(0, 15));
      wr_en    = ($urandom_range(0, 5) == 0);
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = 2'($urandom_range(0, 3));
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
